// File: rtl/spi_cmd_decoder.sv
// spi_cmd_decoder: register read/write protocol over bytes from the SPI receiver.
// Optional idle-frame timeout is built only when SPI_CMD_TIMEOUT_EN is defined.
module spi_cmd_decoder #(
    parameter int NUM_REGS       = 8,
    parameter int TIMEOUT_CYCLES = 16000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            rx_byte,
    input  logic                  rx_valid,
    input  logic                  frame_rst,
    output logic [7:0]            tx_byte,
    output logic [8*NUM_REGS-1:0] regs_flat,
    output logic                  wr_strobe,
    output logic [6:0]            wr_addr,
    output logic                  frame_active
);
    localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [7:0] IDLE_BYTE  = 8'hA5;
    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_READ  = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [6:0]  ptr_q, ptr_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  regs_q [NUM_REGS];
    logic        wr_strobe_q;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic        frame_active_q;
    logic        wr_en_s;
    logic        timeout_s;
    logic        abort_s;
    logic        ptr_in_range_s;
    logic        cmd_in_range_s;
    logic [7:0]  ptr_rd_s;
    logic [7:0]  cmd_rd_s;

    if (NUM_REGS < 1 || NUM_REGS > 128 || TIMEOUT_CYCLES < 1) begin : g_param_err
        $error("spi_cmd_decoder: NUM_REGS must be 1..128 and TIMEOUT_CYCLES >= 1");
    end

    function automatic logic addr_in_range(input logic [6:0] addr);
        return ({1'b0, addr} < NUM_REGS_B);
    endfunction

`ifdef SPI_CMD_TIMEOUT_EN
    localparam int          CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO_LIMIT = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] TMO_ONE   = CW'(1'b1);
    localparam logic [CW-1:0] TMO_ZERO  = CW'(1'b0);

    logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Idle-cycle counter: runs only while a frame is open and no byte arrives.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if ((state_q == ST_IDLE) || rx_valid) begin
            tmo_cnt_d = TMO_ZERO;
        end else begin
            tmo_cnt_d = tmo_cnt_q + TMO_ONE;
        end
    end

    // Timeout counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo_cnt_q <= TMO_ZERO;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end

    assign timeout_s = (state_q != ST_IDLE) && (tmo_cnt_q == TMO_LIMIT);
`else
    assign timeout_s = 1'b0;
`endif

    // A byte arriving in the expiry cycle keeps the frame alive.
    assign abort_s        = frame_rst | (timeout_s & ~rx_valid);
    assign ptr_in_range_s = addr_in_range(ptr_q);
    assign cmd_in_range_s = addr_in_range(rx_byte[6:0]);
    assign ptr_rd_s       = ptr_in_range_s ? regs_q[ptr_q[AW-1:0]] : 8'h00;
    assign cmd_rd_s       = cmd_in_range_s ? regs_q[rx_byte[AW-1:0]] : 8'h00;

    // Next-state and datapath decode for one received byte.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        tx_d      = tx_q;
        wr_addr_d = wr_addr_q;
        wr_en_s   = 1'b0;
        if (abort_s) begin
            state_d = ST_IDLE;
            tx_d    = IDLE_BYTE;
        end else if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte[7]) begin
                        state_d = ST_WRITE;
                        ptr_d   = rx_byte[6:0];
                        tx_d    = IDLE_BYTE;
                    end else begin
                        state_d = ST_READ;
                        ptr_d   = rx_byte[6:0] + 7'd1;
                        tx_d    = cmd_rd_s;
                    end
                end
                ST_WRITE: begin
                    if (ptr_in_range_s) begin
                        wr_en_s   = 1'b1;
                        wr_addr_d = ptr_q;
                    end else begin
                        wr_en_s   = 1'b0;
                    end
                    ptr_d = ptr_q + 7'd1;
                    tx_d  = IDLE_BYTE;
                end
                ST_READ: begin
                    ptr_d = ptr_q + 7'd1;
                    tx_d  = ptr_rd_s;
                end
                default: begin
                    state_d = ST_IDLE;
                    tx_d    = IDLE_BYTE;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            ptr_q          <= 7'd0;
            tx_q           <= IDLE_BYTE;
            wr_strobe_q    <= 1'b0;
            wr_addr_q      <= 7'd0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            tx_q           <= tx_d;
            wr_strobe_q    <= wr_en_s;
            wr_addr_q      <= wr_addr_d;
            frame_active_q <= (state_d != ST_IDLE);
        end
    end

    // Register bank; write data is the byte being sampled on this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else if (wr_en_s) begin
            regs_q[ptr_q[AW-1:0]] <= rx_byte;
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs_q[g];
    end

    assign tx_byte      = tx_q;
    assign wr_strobe    = wr_strobe_q;
    assign wr_addr      = wr_addr_q;
    assign frame_active = frame_active_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: stimulus pushes expected tx bytes and
// register writes; a monitor pops and compares them as the DUT responds.
module tb_spi_cmd_decoder;
    localparam int NUM_REGS = 8;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_exp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [7:0]            rx_byte = 8'h00;
    logic                  rx_valid = 1'b0;
    logic                  frame_rst = 1'b0;
    logic [7:0]            tx_byte;
    logic [8*NUM_REGS-1:0] regs_flat;
    logic                  wr_strobe;
    logic [6:0]            wr_addr;
    logic                  frame_active;

    logic [7:0] exp_tx [$];
    wr_exp_t    exp_wr [$];
    int         vecs = 0;
    int         errs = 0;

    spi_cmd_decoder #(.NUM_REGS(NUM_REGS), .TIMEOUT_CYCLES(20)) dut (
        .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
        .frame_rst(frame_rst), .tx_byte(tx_byte), .regs_flat(regs_flat),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr), .frame_active(frame_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; drives one byte for one cycle and returns at posedge+1.
    task automatic put(input logic [7:0] b, input logic [7:0] tx_exp);
        exp_tx.push_back(tx_exp);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic exp_write(input int a, input logic [7:0] d);
        wr_exp_t w;
        w.addr = a;
        w.data = d;
        exp_wr.push_back(w);
    endtask

    task automatic abort_frame();
        frame_rst = 1'b1;
        @(posedge clk); #1;
        frame_rst = 1'b0;
    endtask

    task automatic monitor();
        logic       seen;
        logic [7:0] e;
        wr_exp_t    w;
        forever begin
            @(posedge clk);
            seen = rx_valid & ~frame_rst & rst;
            @(negedge clk);
            if (seen) begin
                if (exp_tx.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL tx_unexpected: got %02h with no expectation", tx_byte);
                end else begin
                    e = exp_tx.pop_front();
                    chk("tx_byte", 64'(tx_byte), 64'(e));
                end
            end
            if (wr_strobe) begin
                if (exp_wr.size() == 0) begin
                    vecs++; errs++;
                    $display("FAIL wr_unexpected: got wr_addr %0d, expected no strobe", wr_addr);
                end else begin
                    w = exp_wr.pop_front();
                    chk("wr_addr", 64'(wr_addr), 64'(w.addr));
                    chk("wr_data", 64'(regs_flat[8*w.addr +: 8]), 64'(w.data));
                end
            end
        end
    endtask

    initial begin
        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: bench did not complete, expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_tx", 64'(tx_byte), 64'h00A5);
        chk("rst_regs", 64'(regs_flat), 64'h0);
        chk("rst_active", 64'(frame_active), 64'h0);
        chk("rst_strobe", 64'(wr_strobe), 64'h0);

        // write frame 0x82, 0x11, 0x22
        put(8'h82, 8'hA5);
        chk("active_after_cmd", 64'(frame_active), 64'h1);
        exp_write(2, 8'h11); put(8'h11, 8'hA5);
        exp_write(3, 8'h22); put(8'h22, 8'hA5);
        abort_frame();
        chk("wr_idle", 64'(frame_active), 64'h0);
        chk("wr_tx_idle", 64'(tx_byte), 64'h00A5);
        chk("reg2", 64'(regs_flat[23:16]), 64'h11);
        chk("reg3", 64'(regs_flat[31:24]), 64'h22);

        // read frame after the write
        repeat (2) @(posedge clk); #1;
        put(8'h02, 8'h11);
        put(8'h00, 8'h22);
        put(8'h00, 8'h00);
        abort_frame();

        // out-of-range write at 127 then wrap to 0
        put(8'hFF, 8'hA5);
        put(8'h55, 8'hA5);
        exp_write(0, 8'h66); put(8'h66, 8'hA5);
        abort_frame();

        // back-to-back write burst at reg4..6
        put(8'h84, 8'hA5);
        exp_write(4, 8'hA1); put(8'hA1, 8'hA5);
        exp_write(5, 8'hB2); put(8'hB2, 8'hA5);
        exp_write(6, 8'hC3); put(8'hC3, 8'hA5);
        abort_frame();
        chk("regs_all", 64'(regs_flat), 64'h00C3_B2A1_2211_0066);

        // back-to-back read: reg4..7 then out-of-range addr 8
        put(8'h04, 8'hA1);
        put(8'h00, 8'hB2);
        put(8'h00, 8'hC3);
        put(8'h00, 8'h00);
        put(8'h00, 8'h00);
        abort_frame();

        // read starting at 127: out of range, then wrap to reg0, reg1
        put(8'h7F, 8'h00);
        put(8'h00, 8'h66);
        put(8'h00, 8'h00);
        abort_frame();

        // frame_rst wins over a simultaneous byte in WRITE
        put(8'h81, 8'hA5);
        rx_byte   = 8'h81;
        rx_valid  = 1'b1;
        frame_rst = 1'b1;
        @(posedge clk); #1;
        rx_valid  = 1'b0;
        frame_rst = 1'b0;
        @(posedge clk); #1;
        chk("collide_reg1", 64'(regs_flat[15:8]), 64'h00);
        chk("collide_idle", 64'(frame_active), 64'h0);
        chk("collide_tx", 64'(tx_byte), 64'h00A5);

`ifdef SPI_CMD_TIMEOUT_EN
        put(8'h80, 8'hA5);
        repeat (20) @(posedge clk);
        #1;
        chk("tmo_still_open", 64'(frame_active), 64'h1);
        @(posedge clk); #1;
        chk("tmo_expired", 64'(frame_active), 64'h0);
        chk("tmo_tx", 64'(tx_byte), 64'h00A5);
        put(8'h05, 8'hB2);
        chk("tmo_read_active", 64'(frame_active), 64'h1);
        abort_frame();
`endif

        repeat (3) @(posedge clk); #1;
        chk("tx_queue_empty", 64'(exp_tx.size()), 64'h0);
        chk("wr_queue_empty", 64'(exp_wr.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
